// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the lab CPU control sequencer: stage codes, decoded
// opcode types and the bit positions of the decode group vector.
package control_sequencer_pkg;

    localparam int STAGE_WIDTH  = 3;
    localparam int OPCODE_COUNT = 6;
    localparam int GROUP_COUNT  = 9;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_RESET = 3'd0,
        STAGE_IF    = 3'd1,
        STAGE_ID    = 3'd2,
        STAGE_EX    = 3'd3,
        STAGE_MEM   = 3'd4,
        STAGE_WB    = 3'd5
    } stage_e;

    localparam logic [OPCODE_COUNT-1:0] TYPE_UNKNOWN = 6'd0;
    localparam logic [OPCODE_COUNT-1:0] TYPE_NOP     = 6'd1;
    localparam logic [OPCODE_COUNT-1:0] TYPE_ADD     = 6'd2;
    localparam logic [OPCODE_COUNT-1:0] TYPE_CP      = 6'd3;
    localparam logic [OPCODE_COUNT-1:0] TYPE_IN      = 6'd4;
    localparam logic [OPCODE_COUNT-1:0] TYPE_OUT     = 6'd5;
    localparam logic [OPCODE_COUNT-1:0] TYPE_LDS     = 6'd6;
    localparam logic [OPCODE_COUNT-1:0] TYPE_STS     = 6'd7;
    localparam logic [OPCODE_COUNT-1:0] TYPE_RCALL   = 6'd8;
    localparam logic [OPCODE_COUNT-1:0] TYPE_RET     = 6'd9;
    localparam logic [OPCODE_COUNT-1:0] TYPE_SBI     = 6'd10;
    localparam logic [OPCODE_COUNT-1:0] TYPE_CBI     = 6'd11;

    localparam int GROUP_ALU           = 0;
    localparam int GROUP_REGISTER      = 1;
    localparam int GROUP_MEMORY        = 2;
    localparam int GROUP_LOAD          = 3;
    localparam int GROUP_STORE         = 4;
    localparam int GROUP_STACK         = 5;
    localparam int GROUP_IO_READ       = 6;
    localparam int GROUP_IO_WRITE      = 7;
    localparam int GROUP_TWO_CYCLE_MEM = 8;

    // CP only sets flags and RET pops into the PC, so neither writes a register.
    function automatic logic rf_writes(input logic [OPCODE_COUNT-1:0] op_type,
                                       input logic [GROUP_COUNT-1:0]  op_group);
        rf_writes = (op_group[GROUP_ALU]  && (op_type != TYPE_CP))  ||
                    op_group[GROUP_REGISTER]                         ||
                    (op_group[GROUP_LOAD] && (op_type != TYPE_RET)) ||
                    (op_type == TYPE_IN);
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: steps each instruction through IF/ID/EX/MEM/WB and
// decodes the datapath enables from the current stage and the decode groups.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_COUNT-1:0] opcode_type,
    input  logic [GROUP_COUNT-1:0]  opcode_group,
    input  logic                    mem_ready,
    output logic [STAGE_WIDTH-1:0]  pipeline_stage,
    output logic                    ir_en,
    output logic                    pc_en,
    output logic                    mem_rd_en,
    output logic                    mem_wr_en,
    output logic                    io_rd_en,
    output logic                    io_wr_en,
    output logic                    rf_wr_en,
    output logic                    sp_update,
    output logic                    mem_phase,
    output logic                    illegal,
    output logic [COUNT_WIDTH-1:0]  instr_count
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    stage_e                 state_q, state_d;
    logic [BOOT_W-1:0]      boot_q, boot_d;
    logic                   phase_q, phase_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // State, boot countdown, transfer phase and retire counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STAGE_RESET;
            boot_q  <= BOOT_W'(BOOT_CYCLES - 1);
            phase_q <= 1'b0;
            count_q <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            phase_q <= phase_d;
            count_q <= count_d;
        end
    end

    // Next-state logic, including MEM stretching for wait states and two-cycle ops.
    always_comb begin
        state_d = state_q;
        boot_d  = boot_q;
        phase_d = phase_q;
        count_d = count_q;
        case (state_q)
            STAGE_RESET: begin
                if (boot_q == {BOOT_W{1'b0}}) begin
                    state_d = STAGE_IF;
                end else begin
                    boot_d = boot_q - BOOT_W'(1);
                end
            end
            STAGE_IF: state_d = STAGE_ID;
            STAGE_ID: begin
                if (opcode_type == TYPE_UNKNOWN) begin
                    state_d = STAGE_IF;
                end else begin
                    state_d = STAGE_EX;
                end
            end
            STAGE_EX: state_d = STAGE_MEM;
            STAGE_MEM: begin
                if (!opcode_group[GROUP_MEMORY]) begin
                    state_d = STAGE_WB;
                    phase_d = 1'b0;
                end else if (!mem_ready) begin
                    state_d = STAGE_MEM;
                end else if (opcode_group[GROUP_TWO_CYCLE_MEM] && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    state_d = STAGE_WB;
                    phase_d = 1'b0;
                end
            end
            STAGE_WB: begin
                state_d = STAGE_IF;
                count_d = count_q + COUNT_WIDTH'(1);
            end
            default: begin
                state_d = STAGE_RESET;
                phase_d = 1'b0;
            end
        endcase
    end

    // Moore output decode from the registered stage and the held decode inputs.
    always_comb begin
        ir_en     = (state_q == STAGE_IF);
        pc_en     = (state_q == STAGE_WB);
        io_rd_en  = (state_q == STAGE_EX)  && opcode_group[GROUP_IO_READ];
        mem_rd_en = (state_q == STAGE_MEM) && opcode_group[GROUP_LOAD];
        mem_wr_en = (state_q == STAGE_MEM) && opcode_group[GROUP_STORE];
        io_wr_en  = (state_q == STAGE_WB)  && opcode_group[GROUP_IO_WRITE];
        sp_update = (state_q == STAGE_WB)  && opcode_group[GROUP_STACK];
        rf_wr_en  = (state_q == STAGE_WB)  && rf_writes(opcode_type, opcode_group);
        illegal   = (state_q == STAGE_ID)  && (opcode_type == TYPE_UNKNOWN);
    end

    assign pipeline_stage = state_q;
    assign mem_phase      = phase_q;
    assign instr_count    = count_q;

endmodule
